// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shared 64-bit memory port arbiter between instruction fetch and load/store access
// Optional feature: MEM_MISALIGN_TRAP_EN traps misaligned data accesses instead of issuing them.
module mem_port_arbiter #(
  parameter int XLEN    = 64,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_req,
  input  logic [XLEN-1:0]   fetch_addr,
  output logic              fetch_rvalid,
  output logic [31:0]       fetch_rdata,
  input  logic              data_req,
  input  logic              data_we,
  input  logic [2:0]        data_funct3,
  input  logic [XLEN-1:0]   data_addr,
  input  logic [XLEN-1:0]   data_wdata,
  output logic              data_rvalid,
  output logic [XLEN-1:0]   data_rdata,
  output logic              bus_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [XLEN-1:0]   mem_addr,
  output logic [XLEN/8-1:0] mem_be,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic              mem_ready,
  input  logic              mem_rvalid,
  input  logic [XLEN-1:0]   mem_rdata,
`ifdef MEM_MISALIGN_TRAP_EN
  output logic              misalign,
`endif
  output logic              stall_f,
  output logic              stall_m
);

  localparam int LANES = XLEN / 8;
  localparam int OB    = $clog2(LANES);
  localparam int CW    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [2:0] {S_IDLE, S_REQ_F, S_REQ_D, S_WAIT_F, S_WAIT_D} state_t;

  state_t            state_q, nxt_state;
  logic              owner_q, nxt_owner;   // 1 = data owned the port last
  logic [CW-1:0]     cnt_q, nxt_cnt;
  logic [XLEN-1:0]   addr_q, nxt_addr;
  logic              we_q, nxt_we;
  logic [LANES-1:0]  be_q, nxt_be;
  logic [XLEN-1:0]   wdata_q, nxt_wdata;
  logic [OB-1:0]     off_q, nxt_off;
  logic [2:0]        f3_q, nxt_f3;
  logic              nxt_fetch_rvalid, nxt_data_rvalid, nxt_bus_err;
  logic [31:0]       nxt_fetch_rdata;
  logic [XLEN-1:0]   nxt_data_rdata;
`ifdef MEM_MISALIGN_TRAP_EN
  logic              nxt_misalign;
  logic              d_mis;
`endif

  logic              f_want, d_want, tmo, issue_d;
  logic [OB-1:0]     amask, d_off, f_off;
  logic [LANES-1:0]  be_base;
  logic [XLEN-1:0]   shifted, ld_val;

  // A requester whose response is pulsing this cycle is still holding req; don't regrant it.
  assign f_want  = fetch_req & ~fetch_rvalid;
  assign d_want  = data_req & ~data_rvalid;
  assign stall_f = f_want;
  assign stall_m = d_want;

  assign mem_req   = (state_q == S_REQ_F) || (state_q == S_REQ_D);
  assign mem_we    = mem_req & we_q;
  assign mem_addr  = addr_q;
  assign mem_be    = be_q;
  assign mem_wdata = wdata_q;

  assign tmo = (TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT));

  always_comb begin
    amask   = '0;
    be_base = LANES'(1);
    case (data_funct3[1:0])
      2'b00: begin amask = '0;      be_base = LANES'(1);  end
      2'b01: begin amask = OB'(1);  be_base = LANES'(3);  end
      2'b10: begin amask = OB'(3);  be_base = LANES'(15); end
      default: begin amask = '1;    be_base = '1;         end
    endcase
  end

  assign d_off = data_addr[OB-1:0] & ~amask;
  assign f_off = fetch_addr[OB-1:0] & ~OB'(3);
`ifdef MEM_MISALIGN_TRAP_EN
  assign d_mis = |(data_addr[OB-1:0] & amask);
`endif

  assign shifted = mem_rdata >> {off_q, 3'b000};

  always_comb begin
    ld_val = shifted;
    case (f3_q)
      3'b000: ld_val = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
      3'b001: ld_val = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
      3'b010: ld_val = {{(XLEN-32){shifted[31]}}, shifted[31:0]};
      3'b100: ld_val = {{(XLEN-8){1'b0}}, shifted[7:0]};
      3'b101: ld_val = {{(XLEN-16){1'b0}}, shifted[15:0]};
      3'b110: ld_val = {{(XLEN-32){1'b0}}, shifted[31:0]};
      default: ld_val = shifted;
    endcase
  end

  always_comb begin
    nxt_state        = state_q;
    nxt_owner        = owner_q;
    nxt_addr         = addr_q;
    nxt_we           = we_q;
    nxt_be           = be_q;
    nxt_wdata        = wdata_q;
    nxt_off          = off_q;
    nxt_f3           = f3_q;
    nxt_fetch_rvalid = 1'b0;
    nxt_data_rvalid  = 1'b0;
    nxt_bus_err      = 1'b0;
    nxt_fetch_rdata  = fetch_rdata;
    nxt_data_rdata   = data_rdata;
    issue_d          = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
    nxt_misalign     = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (d_want && (!f_want || !owner_q)) begin
          nxt_owner = 1'b1;
`ifdef MEM_MISALIGN_TRAP_EN
          if (d_mis) begin
            nxt_data_rvalid = 1'b1;
            nxt_bus_err     = 1'b1;
            nxt_misalign    = 1'b1;
            nxt_data_rdata  = '0;
          end else begin
            issue_d = 1'b1;
          end
`else
          issue_d = 1'b1;
`endif
        end else if (f_want) begin
          nxt_owner = 1'b0;
          nxt_state = S_REQ_F;
          nxt_addr  = {fetch_addr[XLEN-1:OB], {OB{1'b0}}};
          nxt_we    = 1'b0;
          nxt_be    = LANES'(15) << f_off;
          nxt_wdata = '0;
          nxt_off   = f_off;
          nxt_f3    = 3'b110;
        end
        if (issue_d) begin
          nxt_state = S_REQ_D;
          nxt_addr  = {data_addr[XLEN-1:OB], {OB{1'b0}}};
          nxt_we    = data_we;
          nxt_be    = be_base << d_off;
          nxt_wdata = data_wdata << {d_off, 3'b000};
          nxt_off   = d_off;
          nxt_f3    = data_funct3;
        end
      end
      S_REQ_F: if (mem_ready) nxt_state = S_WAIT_F;
      S_REQ_D: if (mem_ready) nxt_state = S_WAIT_D;
      S_WAIT_F: begin
        if (mem_rvalid) begin
          nxt_state        = S_IDLE;
          nxt_fetch_rvalid = 1'b1;
          nxt_fetch_rdata  = shifted[31:0];
        end
      end
      S_WAIT_D: begin
        if (mem_rvalid) begin
          nxt_state       = S_IDLE;
          nxt_data_rvalid = 1'b1;
          nxt_data_rdata  = we_q ? '0 : ld_val;
        end
      end
      default: nxt_state = S_IDLE;
    endcase

    // Timeout only fires when the transaction made no progress this cycle.
    if (state_q != S_IDLE && nxt_state == state_q && tmo) begin
      nxt_state   = S_IDLE;
      nxt_bus_err = 1'b1;
      if (state_q == S_REQ_F || state_q == S_WAIT_F) begin
        nxt_fetch_rvalid = 1'b1;
        nxt_fetch_rdata  = '0;
      end else begin
        nxt_data_rvalid = 1'b1;
        nxt_data_rdata  = '0;
      end
    end

    nxt_cnt = (state_q != S_IDLE && nxt_state == state_q) ? cnt_q + CW'(1) : '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      owner_q      <= 1'b1;
      cnt_q        <= '0;
      addr_q       <= '0;
      we_q         <= 1'b0;
      be_q         <= '0;
      wdata_q      <= '0;
      off_q        <= '0;
      f3_q         <= '0;
      fetch_rvalid <= 1'b0;
      data_rvalid  <= 1'b0;
      bus_err      <= 1'b0;
      fetch_rdata  <= '0;
      data_rdata   <= '0;
`ifdef MEM_MISALIGN_TRAP_EN
      misalign     <= 1'b0;
`endif
    end else begin
      state_q      <= nxt_state;
      owner_q      <= nxt_owner;
      cnt_q        <= nxt_cnt;
      addr_q       <= nxt_addr;
      we_q         <= nxt_we;
      be_q         <= nxt_be;
      wdata_q      <= nxt_wdata;
      off_q        <= nxt_off;
      f3_q         <= nxt_f3;
      fetch_rvalid <= nxt_fetch_rvalid;
      data_rvalid  <= nxt_data_rvalid;
      bus_err      <= nxt_bus_err;
      fetch_rdata  <= nxt_fetch_rdata;
      data_rdata   <= nxt_data_rdata;
`ifdef MEM_MISALIGN_TRAP_EN
      misalign     <= nxt_misalign;
`endif
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter with a 1-cycle memory model
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_req, fetch_rvalid;
  logic [63:0] fetch_addr;
  logic [31:0] fetch_rdata;
  logic        data_req, data_we, data_rvalid, bus_err;
  logic [2:0]  data_funct3;
  logic [63:0] data_addr, data_wdata, data_rdata;
  logic        mem_req, mem_we, mem_ready, mem_rvalid;
  logic [63:0] mem_addr, mem_wdata, mem_rdata;
  logic [7:0]  mem_be;
  logic        stall_f, stall_m;
`ifdef MEM_MISALIGN_TRAP_EN
  logic        misalign;
`endif

  always #5 clk = ~clk;

  mem_port_arbiter #(.XLEN(64), .TIMEOUT(4)) dut (
    .clk(clk), .reset(reset),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .fetch_rvalid(fetch_rvalid), .fetch_rdata(fetch_rdata),
    .data_req(data_req), .data_we(data_we), .data_funct3(data_funct3),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_rvalid(data_rvalid), .data_rdata(data_rdata), .bus_err(bus_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata),
`ifdef MEM_MISALIGN_TRAP_EN
    .misalign(misalign),
`endif
    .stall_f(stall_f), .stall_m(stall_m)
  );

  typedef struct {
    logic        is_d;
    logic [63:0] rdata;
    logic        err;
    logic        mis;
    int          lat;
    int          t0;
  } rsp_t;

  typedef struct {
    logic [63:0] addr;
    logic        we;
    logic [7:0]  be;
    logic [63:0] wdata;
  } req_t;

  rsp_t        rq[$];
  req_t        mq[$];
  rsp_t        mr;
  req_t        mm;
  int          n_chk = 0;
  int          n_fail = 0;
  int          cyc = 0;
  logic [63:0] rsp_data = '0;
  logic        mem_acc;
  logic [63:0] msk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Memory model: responds one cycle after each accepted request.
  initial begin
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    forever begin
      @(negedge clk);
      mem_acc = mem_req & mem_ready;
      @(posedge clk);
      #1;
      mem_rvalid = mem_acc;
      mem_rdata  = mem_acc ? rsp_data : 64'h0;
    end
  end

  // Monitor: pops expected responses and expected port requests.
  initial forever begin
    @(negedge clk);
    if (!reset) begin
      if (fetch_rvalid || data_rvalid) begin
        if (rq.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_rsp: got fetch=%b data=%b expected none", fetch_rvalid, data_rvalid);
        end else begin
          mr = rq.pop_front();
          chk("rsp_kind", {63'd0, data_rvalid}, {63'd0, mr.is_d});
          chk("rsp_single", {63'd0, fetch_rvalid & data_rvalid}, 64'd0);
          chk("rsp_rdata", mr.is_d ? data_rdata : {32'd0, fetch_rdata}, mr.rdata);
          chk("bus_err", {63'd0, bus_err}, {63'd0, mr.err});
`ifdef MEM_MISALIGN_TRAP_EN
          chk("misalign", {63'd0, misalign}, {63'd0, mr.mis});
`endif
          if (mr.lat >= 0) chk("latency", 64'(cyc - mr.t0), 64'(mr.lat));
        end
      end
      if (mem_req && mem_ready) begin
        if (mq.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_mem_req: got addr %h expected none", mem_addr);
        end else begin
          mm = mq.pop_front();
          for (int i = 0; i < 8; i++) msk[i*8 +: 8] = {8{mm.be[i]}};
          chk("mem_addr", mem_addr, mm.addr);
          chk("mem_we", {63'd0, mem_we}, {63'd0, mm.we});
          chk("mem_be", {56'd0, mem_be}, {56'd0, mm.be});
          chk("mem_wdata", mem_wdata & msk, mm.wdata & msk);
        end
      end
    end
  end

  task automatic fetch_op(input logic [63:0] addr, input logic [63:0] mrd,
                          input logic [63:0] exp_addr, input logic [7:0] exp_be,
                          input logic [63:0] exp_rd);
    rsp_t r;
    req_t m;
    logic got;
    @(negedge clk);
    rsp_data = mrd;
    r.is_d = 1'b0; r.rdata = exp_rd; r.err = 1'b0; r.mis = 1'b0; r.lat = 3; r.t0 = cyc;
    m.addr = exp_addr; m.we = 1'b0; m.be = exp_be; m.wdata = '0;
    rq.push_back(r);
    mq.push_back(m);
    fetch_addr = addr;
    fetch_req  = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      got = fetch_rvalid;
    end
    chk("fetch_done", {63'd0, got}, 64'd1);
    fetch_req = 1'b0;
  endtask

  task automatic data_op(input logic we, input logic [2:0] f3, input logic [63:0] addr,
                         input logic [63:0] wd, input logic [63:0] mrd, input logic issue,
                         input logic [63:0] exp_addr, input logic [7:0] exp_be,
                         input logic [63:0] exp_wd, input logic [63:0] exp_rd,
                         input logic err, input logic mis, input int lat);
    rsp_t r;
    req_t m;
    logic got;
    @(negedge clk);
    rsp_data = mrd;
    r.is_d = 1'b1; r.rdata = exp_rd; r.err = err; r.mis = mis; r.lat = lat; r.t0 = cyc;
    m.addr = exp_addr; m.we = we; m.be = exp_be; m.wdata = exp_wd;
    rq.push_back(r);
    if (issue) mq.push_back(m);
    data_we     = we;
    data_funct3 = f3;
    data_addr   = addr;
    data_wdata  = wd;
    data_req    = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      got = data_rvalid;
    end
    chk("data_done", {63'd0, got}, 64'd1);
    data_req = 1'b0;
  endtask

  initial begin
    int   cnt;
    rsp_t r;
    req_t m;
    reset = 1'b1;
    fetch_req = 1'b0; fetch_addr = '0;
    data_req = 1'b0; data_we = 1'b0; data_funct3 = '0; data_addr = '0; data_wdata = '0;
    mem_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_mem_req", {63'd0, mem_req}, 64'd0);
    chk("rst_mem_be", {56'd0, mem_be}, 64'd0);
    chk("rst_fetch_rvalid", {63'd0, fetch_rvalid}, 64'd0);
    chk("rst_data_rvalid", {63'd0, data_rvalid}, 64'd0);
    chk("rst_bus_err", {63'd0, bus_err}, 64'd0);
    chk("rst_data_rdata", data_rdata, 64'd0);
    chk("rst_fetch_rdata", {32'd0, fetch_rdata}, 64'd0);
    chk("rst_stalls", {62'd0, stall_f, stall_m}, 64'd0);
    reset = 1'b0;

    fetch_op(64'h1004, 64'hAAAA_BBBB_1111_2222, 64'h1000, 8'hF0, 64'hAAAA_BBBB);
    data_op(1'b0, 3'b000, 64'h2003, 64'h0, 64'h0000_0000_8000_0000, 1'b1,
            64'h2000, 8'h08, 64'h0, 64'hFFFF_FFFF_FFFF_FF80, 1'b0, 1'b0, 3);
    data_op(1'b0, 3'b100, 64'h2003, 64'h0, 64'h0000_0000_8000_0000, 1'b1,
            64'h2000, 8'h08, 64'h0, 64'h80, 1'b0, 1'b0, 3);
    data_op(1'b1, 3'b001, 64'h2006, 64'h1234, 64'hDEAD_BEEF_DEAD_BEEF, 1'b1,
            64'h2000, 8'hC0, 64'h1234_0000_0000_0000, 64'h0, 1'b0, 1'b0, 3);
    data_op(1'b0, 3'b010, 64'h2004, 64'h0, 64'h89AB_CDEF_0000_0000, 1'b1,
            64'h2000, 8'hF0, 64'h0, 64'hFFFF_FFFF_89AB_CDEF, 1'b0, 1'b0, 3);
    data_op(1'b0, 3'b110, 64'h2004, 64'h0, 64'h89AB_CDEF_0000_0000, 1'b1,
            64'h2000, 8'hF0, 64'h0, 64'h0000_0000_89AB_CDEF, 1'b0, 1'b0, 3);
    data_op(1'b0, 3'b101, 64'h2002, 64'h0, 64'h0000_0000_F00D_0000, 1'b1,
            64'h2000, 8'h0C, 64'h0, 64'hF00D, 1'b0, 1'b0, 3);
    data_op(1'b0, 3'b001, 64'h2002, 64'h0, 64'h0000_0000_F00D_0000, 1'b1,
            64'h2000, 8'h0C, 64'h0, 64'hFFFF_FFFF_FFFF_F00D, 1'b0, 1'b0, 3);
    data_op(1'b0, 3'b011, 64'h2008, 64'h0, 64'h0123_4567_89AB_CDEF, 1'b1,
            64'h2008, 8'hFF, 64'h0, 64'h0123_4567_89AB_CDEF, 1'b0, 1'b0, 3);
    data_op(1'b0, 3'b111, 64'h2010, 64'h0, 64'hFEDC_BA98_7654_3210, 1'b1,
            64'h2010, 8'hFF, 64'h0, 64'hFEDC_BA98_7654_3210, 1'b0, 1'b0, 3);
`ifdef MEM_MISALIGN_TRAP_EN
    data_op(1'b0, 3'b010, 64'h3002, 64'h0, 64'h0000_0000_CAFE_BABE, 1'b0,
            64'h3000, 8'h0F, 64'h0, 64'h0, 1'b1, 1'b1, 1);
`else
    data_op(1'b0, 3'b010, 64'h3002, 64'h0, 64'h0000_0000_CAFE_BABE, 1'b1,
            64'h3000, 8'h0F, 64'h0, 64'hFFFF_FFFF_CAFE_BABE, 1'b0, 1'b0, 3);
`endif
    fetch_op(64'h1000, 64'hAAAA_BBBB_1111_2222, 64'h1000, 8'h0F, 64'h1111_2222);

    // Both requesters held: last owner was fetch, so grants go D,F,D,F.
    @(negedge clk);
    rsp_data = 64'h1122_3344_5566_7788;
    for (int k = 0; k < 4; k++) begin
      r.is_d = (k % 2 == 0); r.err = 1'b0; r.mis = 1'b0; r.lat = -1; r.t0 = cyc;
      r.rdata = r.is_d ? 64'h1122_3344_5566_7788 : 64'h5566_7788;
      m.addr = r.is_d ? 64'h2000 : 64'h1000; m.we = 1'b0;
      m.be = r.is_d ? 8'hFF : 8'h0F; m.wdata = '0;
      rq.push_back(r);
      mq.push_back(m);
    end
    fetch_addr = 64'h1000;
    data_we = 1'b0; data_funct3 = 3'b011; data_addr = 64'h2000;
    fetch_req = 1'b1;
    data_req  = 1'b1;
    cnt = 0;
    for (int i = 0; i < 60 && cnt < 4; i++) begin
      @(negedge clk);
      if (fetch_rvalid || data_rvalid) cnt++;
    end
    fetch_req = 1'b0;
    data_req  = 1'b0;
    chk("alt_count", 64'(cnt), 64'd4);

    mem_ready = 1'b0;
    data_op(1'b0, 3'b010, 64'h2000, 64'h0, 64'h0, 1'b0,
            64'h2000, 8'h0F, 64'h0, 64'h0, 1'b1, 1'b0, 6);
    chk("tmo_mem_req_dropped", {63'd0, mem_req}, 64'd0);
    mem_ready = 1'b1;

    fetch_op(64'h1008, 64'h0BAD_F00D_600D_CAFE, 64'h1008, 8'h0F, 64'h600D_CAFE);

    repeat (5) @(negedge clk);
    chk("rsp_queue_empty", 64'(rq.size()), 64'd0);
    chk("mem_queue_empty", 64'(mq.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
